uart_inst_loader: RTL and testbench
===================================

# uart_inst_loader

- UART-to-ICCM boot loader: receives the instruction byte stream that the boot host sends at power-up.
- Frame format is 8N1, LSB first, four bytes per instruction in little-endian order.
- Assembles each group of four bytes into a 32-bit word and writes it to instruction memory through a request/grant port.
- Holds the core in reset (`sys_rst_no`) until an end-of-program marker word arrives; sits between the `uart_rx_inst` pad and the ICCM write port of `opentitan_soc_top`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10417: clk_i cycles per UART bit (100 MHz / 9600 + 1).
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.
- `END_WORD`, 32'h0000_0FFF: marker that terminates the load; it is never written.
- `TIMEOUT_BITS`, 64: idle bit-times before auto-completion (only with the macro).

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `rx_i` in 1: UART serial input; idle high; asynchronous to clk_i.
- `req_o` out 1: write request.
- `addr_o` out 32: word byte address.
- `wdata_o` out 32: instruction word.
- `gnt_i` in 1: write accepted this cycle.
- `done_o` out 1: load complete; sticky.
- `sys_rst_no` out 1: core reset, active low.
- `frame_err_o` out 1: sticky stop-bit error.
- `overflow_o` out 1: sticky, word completed while `req_o` was pending.
- `word_cnt_o` out 16: words written.

## Operation
- `rx_i` passes through a 2-flop synchronizer; all decoding uses the synchronized value.
- Bit FSM states:
  - IDLE: a falling edge goes to START and loads bit counter = CLKS_PER_BIT/2 - 1.
  - START: at counter expiry (mid start bit), line low → DATA with counter = CLKS_PER_BIT - 1; line high → IDLE (glitch, no error).
  - DATA: samples 8 bits at mid-bit, shifting in LSB first; after bit 8 → STOP.
  - STOP: sample high → byte valid; sample low → byte discarded and `frame_err_o` set. Either way → IDLE.
- Byte lane counter (0..3):
  - Byte n goes to `wdata[8n+7:8n]`.
  - On lane 3 the word is complete and the lane wraps to 0.
  - A frame error does not advance the lane.
- Word complete:
  - If word == END_WORD: set `done_o`, no request.
  - Otherwise: assert `req_o` with `addr_o` = BASE_ADDR + 4*`word_cnt_o`.
- Request handshake:
  - `req_o`, `addr_o` and `wdata_o` stay stable until a cycle with `gnt_i` = 1.
  - `req_o` drops the next cycle and `word_cnt_o` increments.
  - A new word completing while `req_o` is still high sets `overflow_o` and drops the new word.
- Done:
  - After `done_o`, all further rx traffic is ignored.
  - `sys_rst_no` = 1 only when `done_o` = 1 and `req_o` = 0.
- `word_cnt_o` saturates at 16'hFFFF.

## Timing
- Reset values:
  - All outputs 0 except: `addr_o` = BASE_ADDR, `sys_rst_no` = 0.
  - FSM in IDLE; synchronizer flops reset to 1.
- rx-to-decode latency: 2 cycles (synchronizer).
- STOP sample to `req_o` (or `done_o`) high: 1 cycle.
- `gnt_i` may be high in the same cycle `req_o` rises; that cycle counts as the accept.
- `done_o` to `sys_rst_no` release: 1 cycle.
- Reset asserted mid-frame or mid-request: everything clears and the partial word is lost.

## Configuration
- `UART_LOADER_TIMEOUT_EN` defined:
  - After the first written word, if the FSM stays in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles with lane = 0, `done_o` sets.
  - Partial lanes never time out.
- Macro undefined: only END_WORD completes the load; no timeout counter is synthesized.

## Structure
- Shared `uart_loader_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Default bit timing localparam.
  - Default END_WORD constant.
- Sub-module `uart_rx_byte`:
  - Contains the synchronizer and bit FSM.
  - Outputs `byte_valid`, `byte_data[7:0]` and `frame_err`.
- Word assembly, write handshake and done logic stay in the top module.

## Test plan
- Bytes 13 01 20 00 sent, `gnt_i` tied 1 → one `req_o` pulse, `addr_o` = 0x0, `wdata_o` = 0x00200113, `word_cnt_o` = 1.
- Two words, then FF 0F 00 00 → `done_o` and `sys_rst_no` high, with 2 writes at 0x0 and 0x4; later bytes produce no request.
- Byte with stop bit 0 between lanes 1 and 2 → `frame_err_o` = 1; the next valid byte fills lane 2 and the word completes normally.
- 0.3-bit low glitch on idle line → no byte, no error.
- `gnt_i` held 0 while a second word completes → first request held stable, `overflow_o` = 1, second word not written.
- With `UART_LOADER_TIMEOUT_EN`, TIMEOUT_BITS = 4, one word then idle → `done_o` after 4*CLKS_PER_BIT ±2 cycles.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART instruction loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // 100 MHz / 9600 baud, rounded up.
  localparam int unsigned DefaultClksPerBit = 10417;
  localparam logic [31:0] DefaultEndWord    = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer plus mid-bit sampling FSM.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            tick;
  logic            fall;

  assign tick = (cnt_q == '0);
  assign fall = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_q <= StStart;
            cnt_q   <= HalfLoad;
          end
        end
        StStart: begin
          if (tick) begin
            // A start bit that is high again by mid-bit is treated as a glitch.
            if (!rx_sync_q) begin
              state_q   <= StData;
              cnt_q     <= FullLoad;
              bit_idx_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (tick) begin
            shreg_q <= {rx_sync_q, shreg_q[7:1]};
            cnt_q   <= FullLoad;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes fire on the stop-bit sample so the loader can register them one cycle later.
  assign byte_valid_o = (state_q == StStop) & tick & rx_sync_q;
  assign frame_err_o  = (state_q == StStop) & tick & ~rx_sync_q;
  assign byte_data_o  = shreg_q;
  assign idle_o       = (state_q == StIdle);

endmodule

// File: rtl/uart_inst_loader.sv
// UART-to-ICCM boot loader: packs bytes into words, writes them, then releases core reset.
// Optional idle auto-completion is enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_inst_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] END_WORD     = DefaultEndWord,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  output logic        done_o,
  output logic        sys_rst_no,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic [15:0] word_cnt_o
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic       rx_idle;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_valid_o(rx_valid),
    .byte_data_o (rx_byte),
    .frame_err_o (rx_ferr),
    .idle_o      (rx_idle)
  );

  logic [1:0]  lane_q;
  logic [23:0] word_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        sys_rst_q;
  logic        frame_err_q;
  logic        overflow_q;
  logic [15:0] word_cnt_q;
  logic [31:0] full_word;
  logic        accept;
  logic        err;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] tmo_q;
`else
  localparam int unsigned UnusedTimeoutBits = TIMEOUT_BITS;
  logic unused_rx_idle;
  assign unused_rx_idle = rx_idle;
`endif

  assign full_word = {rx_byte, word_q};
  assign accept    = rx_valid & ~done_q;
  assign err       = rx_ferr & ~done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q      <= '0;
      word_q      <= '0;
      req_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      sys_rst_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      word_cnt_q  <= '0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      sys_rst_q <= done_q & ~req_q;

      if (err) begin
        frame_err_q <= 1'b1;
      end

      if (req_q && gnt_i) begin
        req_q <= 1'b0;
        if (word_cnt_q != 16'hFFFF) begin
          word_cnt_q <= word_cnt_q + 16'd1;
        end
      end

      if (accept) begin
        if (lane_q == 2'd3) begin
          lane_q <= 2'd0;
          if (full_word == END_WORD) begin
            done_q <= 1'b1;
          end else if (req_q) begin
            // Previous write still pending: the new word is lost.
            overflow_q <= 1'b1;
          end else begin
            req_q   <= 1'b1;
            addr_q  <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            wdata_q <= full_word;
          end
        end else begin
          unique case (lane_q)
            2'd0:    word_q[7:0]   <= rx_byte;
            2'd1:    word_q[15:8]  <= rx_byte;
            default: word_q[23:16] <= rx_byte;
          endcase
          lane_q <= lane_q + 2'd1;
        end
      end

`ifdef UART_LOADER_TIMEOUT_EN
      // Only word-aligned idle after at least one write may end the load.
      if (!done_q && rx_idle && lane_q == 2'd0 && word_cnt_q != '0) begin
        if (tmo_q == TmoLast) begin
          done_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  assign req_o       = req_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign done_o      = done_q;
  assign sys_rst_no  = sys_rst_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader with a write scoreboard.
module tb_uart_inst_loader;

  localparam int unsigned Cpb = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic        gnt_i = 1'b1;
  logic        req_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        done_o;
  logic        sys_rst_no;
  logic        frame_err_o;
  logic        overflow_o;
  logic [15:0] word_cnt_o;

  uart_inst_loader #(
    .CLKS_PER_BIT(Cpb),
    .BASE_ADDR   (32'h0000_0000),
    .END_WORD    (32'h0000_0FFF),
    .TIMEOUT_BITS(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .req_o      (req_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .gnt_i      (gnt_i),
    .done_o     (done_o),
    .sys_rst_no (sys_rst_no),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  logic [63:0] exp_q[$];
  logic        req_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic [31:0] wdata_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rising req_o must match the next queued {addr, data}.
  always @(negedge clk_i) begin
    logic [63:0] e;
    if (req_o && !req_prev) begin
      writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", addr_o, e[63:32]);
        check("write_data", wdata_o, e[31:0]);
      end
    end else if (req_o && req_prev) begin
      check("hold_addr", addr_o, addr_prev);
      check("hold_data", wdata_o, wdata_prev);
    end
    req_prev   = req_o;
    addr_prev  = addr_o;
    wdata_prev = wdata_o;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    wait_cyc(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cyc(Cpb);
    end
    rx_i = stop;
    wait_cyc(Cpb);
    rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i+:8], 1'b1);
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sys_rst", 32'(sys_rst_no), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_cnt", 32'(word_cnt_o), 32'd0);
    rst_ni = 1'b1;
    wait_cyc(4);

    // Short low glitch on the idle line
    rx_i = 1'b0;
    wait_cyc(5);
    rx_i = 1'b1;
    wait_cyc(3 * Cpb);
    check("glitch_ferr", 32'(frame_err_o), 32'd0);
    check("glitch_req", 32'(req_o), 32'd0);
    check("glitch_writes", 32'(writes), 32'd0);

    // First word with gnt tied high
    exp_q.push_back({32'h0, 32'h0020_0113});
    send_word(32'h0020_0113);
    wait_cyc(Cpb);
    check("w0_cnt", 32'(word_cnt_o), 32'd1);
    check("w0_req_low", 32'(req_o), 32'd0);
    check("w0_sys_rst", 32'(sys_rst_no), 32'd0);

    // Framing error between lanes 1 and 2 does not advance the lane
    exp_q.push_back({32'h4, 32'h0010_0593});
    send_byte(8'h93, 1'b1);
    send_byte(8'h05, 1'b1);
    check("ferr_before", 32'(frame_err_o), 32'd0);
    send_byte(8'hAA, 1'b0);
    wait_cyc(Cpb);
    check("ferr_after", 32'(frame_err_o), 32'd1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_cyc(Cpb);
    check("w1_cnt", 32'(word_cnt_o), 32'd2);

    // Grant withheld: second completed word overflows and is dropped
    gnt_i = 1'b0;
    exp_q.push_back({32'h8, 32'h1234_5678});
    send_word(32'h1234_5678);
    wait_cyc(2);
    check("ovf_req_high", 32'(req_o), 32'd1);
    check("ovf_before", 32'(overflow_o), 32'd0);
    send_word(32'hDEAD_BEEF);
    wait_cyc(2);
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_req_held", 32'(req_o), 32'd1);
    check("ovf_data_held", wdata_o, 32'h1234_5678);
    check("ovf_cnt", 32'(word_cnt_o), 32'd2);
    gnt_i = 1'b1;
    wait_cyc(2);
    check("ovf_req_drop", 32'(req_o), 32'd0);
    check("ovf_cnt_after", 32'(word_cnt_o), 32'd3);

    // End marker completes the load; later traffic is ignored
    check("pre_done", 32'(done_o), 32'd0);
    send_word(32'h0000_0FFF);
    wait_cyc(2);
    check("done", 32'(done_o), 32'd1);
    check("sys_rst_rel", 32'(sys_rst_no), 32'd1);
    check("done_req", 32'(req_o), 32'd0);
    send_word(32'h4433_2211);
    wait_cyc(Cpb);
    check("post_done_cnt", 32'(word_cnt_o), 32'd3);
    check("write_count", 32'(writes), 32'd3);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame loses the partial word
    send_byte(8'h6F, 1'b1);
    send_byte(8'h00, 1'b1);
    rx_i = 1'b0;
    wait_cyc(40);
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    wait_cyc(3);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_sys", 32'(sys_rst_no), 32'd0);
    check("mid_rst_cnt", 32'(word_cnt_o), 32'd0);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    check("mid_rst_ferr", 32'(frame_err_o), 32'd0);
    rst_ni = 1'b1;
    wait_cyc(2);
    exp_q.push_back({32'h0, 32'h0040_006F});
    send_word(32'h0040_006F);
    check("rst_word_cnt", 32'(word_cnt_o), 32'd1);
    check("rst_write_count", 32'(writes), 32'd4);

`ifdef UART_LOADER_TIMEOUT_EN
    wait_cyc(40);
    check("tmo_early", 32'(done_o), 32'd0);
    wait_cyc(40);
    check("tmo_done", 32'(done_o), 32'd1);
`else
    wait_cyc(200);
    check("no_tmo", 32'(done_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
